// File: rtl/mem_copy_dma_pkg.sv
// Shared definitions for the block-copy DMA engine.
// Holds RAM port width defaults and the FSM state encoding.
// Imported by the engine and by anything that decodes its state.
package mem_copy_dma_pkg;

  // Default RAM port widths, shared with the RAM and the CPU
  localparam int unsigned MEM_AW = 16;
  localparam int unsigned MEM_DW = 16;
  localparam int unsigned LEN_W  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_READ  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } dma_state_t;

endpackage

// File: rtl/mem_copy_dma.sv
// Block-copy engine: moves len words src->dst over the shared single-port RAM.
// Latency: 2 cycles/word with continuous grant; done in cycle 2N+2 after start.
// Backpressure: waits in REQ without grant; bus released only at word boundaries.
module mem_copy_dma
  import mem_copy_dma_pkg::*;
#(
  parameter int unsigned AW = MEM_AW,
  parameter int unsigned DW = MEM_DW
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [AW-1:0]    i_src,
  input  logic [AW-1:0]    i_dst,
  input  logic [LEN_W-1:0] i_len,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_bus_req,
  input  logic             i_bus_gnt,
  output logic             o_bus_own,
  output logic [AW-1:0]    o_mem_addr,
  output logic [DW-1:0]    o_mem_din,
  output logic             o_mem_we,
  input  logic [DW-1:0]    i_mem_dout
);

  dma_state_t       r_state;
  dma_state_t       w_state_nxt;
  logic [AW-1:0]    r_sp;
  logic [AW-1:0]    r_dp;
  logic [LEN_W-1:0] r_cnt;
  logic             w_cap;
  logic             w_adv;

  // State register; pointers captured on accepted start and stepped on each WRITE exit
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_sp    <= '0;
      r_dp    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_cap) begin
        r_sp  <= i_src;
        r_dp  <= i_dst;
        r_cnt <= i_len;
      end else if (w_adv) begin
        // Pointers wrap naturally modulo 2^AW
        r_sp  <= r_sp + AW'(1);
        r_dp  <= r_dp + AW'(1);
        r_cnt <= r_cnt - LEN_W'(1);
      end
    end
  end

  // Next-state and Moore output decode; bus outputs stay zero unless owned so they can be OR-muxed
  always_comb begin
    w_state_nxt = r_state;
    w_cap       = 1'b0;
    w_adv       = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    o_bus_req   = 1'b0;
    o_bus_own   = 1'b0;
    o_mem_addr  = '0;
    o_mem_din   = '0;
    o_mem_we    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (i_len != '0) begin
            w_cap       = 1'b1;
            w_state_nxt = ST_REQ;
          end else begin
            // Zero-length copy completes without touching the bus
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_REQ: begin
        o_busy    = 1'b1;
        o_bus_req = 1'b1;
        if (i_bus_gnt) begin
          w_state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        o_busy      = 1'b1;
        o_bus_req   = 1'b1;
        o_bus_own   = 1'b1;
        o_mem_addr  = r_sp;
        // A read is always followed by its write, grant or not
        w_state_nxt = ST_WRITE;
      end
      ST_WRITE: begin
        o_busy     = 1'b1;
        o_bus_req  = 1'b1;
        o_bus_own  = 1'b1;
        o_mem_addr = r_dp;
        o_mem_din  = i_mem_dout;
        o_mem_we   = 1'b1;
        w_adv      = 1'b1;
        if (r_cnt == LEN_W'(1)) begin
          w_state_nxt = ST_DONE;
        end else if (i_bus_gnt) begin
          w_state_nxt = ST_READ;
        end else begin
          w_state_nxt = ST_REQ;
        end
      end
      ST_DONE: begin
        o_busy      = 1'b1;
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Bench for mem_copy_dma: RAM model, behavioural copy model and per-cycle scoreboard.
// All checks run in one process on the falling clock edge.
// Inputs are driven right after the checks of each falling edge.
module tb_mem_copy_dma;

  logic        clk = 1'b0;
  logic        rst_n, start, gnt;
  logic [15:0] src, dst, len;
  logic        busy, done, req, own, we;
  logic [15:0] addr, din;
  logic [15:0] dout = '0;

  always #5 clk = ~clk;

  mem_copy_dma #(.AW(16), .DW(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_src(src), .i_dst(dst), .i_len(len),
    .o_busy(busy), .o_done(done), .o_bus_req(req), .i_bus_gnt(gnt), .o_bus_own(own),
    .o_mem_addr(addr), .o_mem_din(din), .o_mem_we(we), .i_mem_dout(dout)
  );

  // RAM model: 1-cycle read latency; unwritten words hold a fixed address hash
  logic [15:0] ram    [0:65535];
  bit          wr_vld [0:65535];
  logic        pl_en = 1'b0;
  logic [15:0] pl_addr = '0, pl_dat = '0;
  int unsigned cyc = 0;

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] rd(input logic [15:0] a);
    return wr_vld[a] ? ram[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    dout <= rd(addr);
    if (we) begin
      ram[addr]    <= din;
      wr_vld[addr] <= 1'b1;
    end else if (pl_en) begin
      ram[pl_addr]    <= pl_dat;
      wr_vld[pl_addr] <= 1'b1;
    end
  end

  // Model and scoreboard state
  logic [15:0] exp_mem [0:65535];
  logic [15:0] rq[$];
  logic [31:0] wq[$];
  int unsigned start_p, xfer_lo, done_cyc, last_we_cyc, done_at;
  int          nwe, ndone, nreq;
  bit          len0, rnd_gnt;
  int          tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Advance one cycle and compare every DUT output against the model
  task automatic tick();
    logic        eb;
    logic [31:0] e;
    @(negedge clk);
    eb = (cyc >= xfer_lo) && (cyc <= done_cyc);
    chk("busy", busy, eb);
    if (!own) begin
      chk("idle_addr", addr, 0);
      chk("idle_din", din, 0);
      chk("idle_we", we, 0);
    end else begin
      chk("own_req", req, 1);
    end
    if (!busy) chk("idle_req", req, 0);
    if (req) nreq++;
    if (own && !we) begin
      chk("read_expected", rq.size() > 0, 1);
      if (rq.size() > 0) chk("read_addr", addr, rq.pop_front());
    end
    if (we) begin
      nwe++;
      last_we_cyc = cyc;
      chk("write_expected", wq.size() > 0, 1);
      if (wq.size() > 0) begin
        e = wq.pop_front();
        chk("wr_addr", addr, e[31:16]);
        chk("wr_data", din, e[15:0]);
      end
    end
    if (done) begin
      ndone++;
      done_at  = cyc;
      done_cyc = cyc;
      chk("done_all_written", wq.size(), 0);
      chk("done_when", cyc, len0 ? start_p + 1 : last_we_cyc + 1);
      chk("done_req", req, 0);
    end
    if (rnd_gnt) gnt = ($urandom_range(0, 3) != 0);
  endtask

  // Expected transfer: ascending word copy applied to the model memory
  task automatic model(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                       input int napply);
    logic [15:0] a, b;
    rq.delete();
    wq.delete();
    for (int i = 0; i < int'(l); i++) begin
      a = s + 16'(i);
      b = d + 16'(i);
      rq.push_back(a);
      wq.push_back({b, exp_mem[a]});
      if (i < napply) exp_mem[b] = exp_mem[a];
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] v);
    pl_en = 1'b1; pl_addr = a; pl_dat = v;
    exp_mem[a] = v;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic go(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                    input int napply);
    src = s; dst = d; len = l; start = 1'b1;
    start_p = cyc; xfer_lo = cyc + 1; done_cyc = '1;
    len0 = (l == 0); nwe = 0; ndone = 0; nreq = 0;
    model(s, d, l, napply);
    tick();
    start = 1'b0;
    src = 16'($urandom); dst = 16'($urandom); len = 16'($urandom);
  endtask

  task automatic wait_done(input int budget);
    int b = 0;
    while (ndone == 0 && b < budget) begin
      tick();
      b++;
    end
    chk("done_seen", ndone != 0, 1);
  endtask

  task automatic wait_we(input int n, input int budget);
    int b = 0;
    while (nwe < n && b < budget) begin
      tick();
      b++;
    end
    chk("writes_seen", nwe >= n, 1);
  endtask

  task automatic cmp_dst(input logic [15:0] d, input logic [15:0] l);
    for (int i = 0; i < int'(l); i++) chk("dst_word", rd(d + 16'(i)), exp_mem[d + 16'(i)]);
  endtask

  task automatic chk_reset_outs();
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_req", req, 0);
    chk("rst_own", own, 0);   chk("rst_we", we, 0);     chk("rst_addr", addr, 0);
    chk("rst_din", din, 0);
  endtask

  logic [15:0] s, d, l;
  int          diffs;

  initial begin
    for (int i = 0; i < 65536; i++) exp_mem[i] = init_val(16'(i));
    xfer_lo = '1; done_cyc = '1; start_p = 0; last_we_cyc = 0; done_at = 0;
    nwe = 0; ndone = 0; nreq = 0; len0 = 0; rnd_gnt = 0;
    rst_n = 1'b0; start = 1'b0; gnt = 1'b0; src = '0; dst = '0; len = '0;
    repeat (3) tick();
    chk_reset_outs();
    rst_n = 1'b1;
    repeat (2) tick();

    // Basic copy with grant tied high
    gnt = 1'b1;
    preload(16'd32, 16'd3); preload(16'd33, 16'd5); preload(16'd34, 16'd7);
    go(16'd32, 16'd64, 16'd3, 3);
    wait_done(50);
    chk("basic_latency", done_at - start_p, 8);
    chk("basic_we_cycles", nwe, 3);
    chk("basic_m64", rd(16'd64), 16'd3);
    chk("basic_m65", rd(16'd65), 16'd5);
    chk("basic_m66", rd(16'd66), 16'd7);
    repeat (3) tick();
    chk("basic_one_done", ndone, 1);

    // Zero length
    go(16'd100, 16'd200, 16'd0, 0);
    wait_done(10);
    chk("zero_latency", done_at - start_p, 1);
    repeat (3) tick();
    chk("zero_no_req", nreq, 0);
    chk("zero_no_we", nwe, 0);
    chk("zero_ram", rd(16'd200), exp_mem[200]);

    // Grant withdrawn for 5 cycles after the 2nd write
    go(16'd300, 16'd400, 16'd4, 4);
    wait_we(2, 20);
    gnt = 1'b0;
    repeat (5) begin
      tick();
      chk("gap_own", own, 0);
      chk("gap_we", we, 0);
      chk("gap_req", req, 1);
    end
    gnt = 1'b1;
    wait_done(50);
    chk("stall_latency", done_at - start_p, 15);
    cmp_dst(16'd400, 16'd4);
    tick();

    // Address wrap-around
    preload(16'hFFFE, 16'hAAAA); preload(16'hFFFF, 16'hBBBB); preload(16'h0000, 16'hCCCC);
    go(16'hFFFE, 16'h0100, 16'd3, 3);
    wait_done(50);
    chk("wrap_m100", rd(16'h0100), 16'hAAAA);
    chk("wrap_m101", rd(16'h0101), 16'hBBBB);
    chk("wrap_m102", rd(16'h0102), 16'hCCCC);
    tick();

    // Reset in the cycle after the 3rd write
    go(16'd500, 16'd600, 16'd10, 3);
    wait_we(3, 30);
    tick();
    rst_n = 1'b0;
    done_cyc = cyc;
    tick();
    rst_n = 1'b1;
    chk_reset_outs();
    rq.delete(); wq.delete();
    repeat (4) tick();
    chk("rst_no_done", ndone, 0);
    chk("rst_3_words", nwe, 3);
    chk("rst_m603", rd(16'd603), exp_mem[603]);
    cmp_dst(16'd600, 16'd3);
    go(16'd700, 16'd800, 16'd2, 2);
    wait_done(30);
    chk("post_rst_latency", done_at - start_p, 6);
    cmp_dst(16'd800, 16'd2);
    tick();

    // Start during READ is ignored, as is start in the DONE cycle
    go(16'd900, 16'd1000, 16'd4, 4);
    tick();
    chk("ign_in_read", {own, we}, 2'b10);
    start = 1'b1; src = 16'd2000; dst = 16'd3000; len = 16'd7;
    tick();
    start = 1'b0;
    wait_done(50);
    chk("ign_latency", done_at - start_p, 10);
    start = 1'b1; src = 16'd4000; dst = 16'd5000; len = 16'd5;
    tick();
    start = 1'b0;
    repeat (15) tick();
    chk("ign_one_done", ndone, 1);
    cmp_dst(16'd1000, 16'd4);

    // Randomized transfers with random grant, including overlap and wrap
    rnd_gnt = 1;
    for (int it = 0; it < 30; it++) begin
      l = 16'($urandom_range(1, 16));
      s = (it % 5 == 0) ? 16'hFFF8 : 16'($urandom);
      d = (it % 3 == 0) ? s + 16'($urandom_range(1, int'(l))) : 16'($urandom);
      go(s, d, l, int'(l));
      wait_done(500);
      tick(); tick();
      chk("rnd_one_done", ndone, 1);
      cmp_dst(d, l);
    end
    rnd_gnt = 0;
    gnt = 1'b1;
    repeat (2) tick();

    // Whole memory must match the model: no stray writes anywhere
    diffs = 0;
    for (int i = 0; i < 65536; i++) if (rd(16'(i)) !== exp_mem[i]) diffs++;
    chk("ram_full", diffs, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
